vga_ram_arbiter: RTL
====================

Name: vga_ram_arbiter

Overview:
Memory-side responder for the VGA text controller's fetch interface. It shares one synchronous single-port RAM between the VGA fetch master and the CPU data bus. The VGA master gives one cycle of advance notice (access request) and then gets absolute priority. CPU accesses are stalled around VGA fetch bursts and are completed with a one-cycle acknowledge.

Parameters:
ADDR_WIDTH, 16, RAM/bus address width
DATA_WIDTH, 8, RAM/bus data width

Ports:
i_clk  input  1  clock; all logic on rising edge
i_reset_n  input  1  asynchronous active-low reset
i_vga_access  input  1  VGA wants the RAM port in the next cycle
i_vga_cs  input  1  VGA RAM access this cycle (read only)
i_vga_addr  input  ADDR_WIDTH  VGA address, valid with i_vga_cs
o_vga_dat  output  DATA_WIDTH  read data of the most recent VGA access
i_cpu_cs  input  1  CPU request; held until o_cpu_ack
i_cpu_we  input  1  CPU write (1) / read (0)
i_cpu_addr  input  ADDR_WIDTH  CPU address
i_cpu_dat  input  DATA_WIDTH  CPU write data
o_cpu_dat  output  DATA_WIDTH  CPU read data
o_cpu_ack  output  1  one-cycle completion pulse
o_ram_cs  output  1  RAM enable
o_ram_we  output  1  RAM write enable
o_ram_addr  output  ADDR_WIDTH  RAM address
o_ram_dat  output  DATA_WIDTH  RAM write data
i_ram_dat  input  DATA_WIDTH  RAM read data; valid the cycle after a read with o_ram_cs=1

Behaviour:
- Reset (async, i_reset_n=0): FSM=IDLE; o_cpu_ack=0; o_cpu_dat=0; VGA data hold register=0; vga_rd_q=0; cpu_rd_q=0.
- RAM port mux (combinational):
  - When i_vga_cs=1: o_ram_cs=1, o_ram_we=0, o_ram_addr=i_vga_addr.
  - Else when a CPU issue occurs: o_ram_cs=1, o_ram_we=i_cpu_we, o_ram_addr=i_cpu_addr, o_ram_dat=i_cpu_dat.
  - Else: o_ram_cs=0, o_ram_we=0, addr=0, dat=0.
- CPU issue condition: FSM=IDLE && i_cpu_cs && !i_vga_access && !i_vga_cs.
  - Consequence: CPU is blocked in the notice cycle and in every VGA cs cycle. A CPU op therefore never overlaps a VGA access.
- FSM:
  - IDLE: on issue -> RESP (record cpu_rd_q = !i_cpu_we). Otherwise stay; the CPU waits indefinitely.
  - RESP: o_cpu_ack=1 (registered, exactly 1 cycle).
    - For a read, o_cpu_dat <= i_ram_dat at the end of RESP; it is also valid combinationally during RESP (mux) and then held.
    - For a write, o_cpu_dat is unchanged.
    - Always -> IDLE.
  - VGA accesses are permitted while in RESP, because the RAM port is free that cycle.
- CPU latency: 2 cycles from issue to end of ack when unblocked (issue cycle + RESP).
  - Back-to-back CPU requests: next issue earliest in the cycle after RESP.
- VGA read path:
  - vga_rd_q <= i_vga_cs.
  - o_vga_dat = vga_rd_q ? i_ram_dat : hold. hold <= i_ram_dat whenever vga_rd_q=1.
  - So o_vga_dat shows data for the address given one cycle earlier and keeps it until the next VGA read result. CPU reads never disturb o_vga_dat.
- Consecutive VGA cs cycles (char fetch, then font fetch) are pipelined: each result appears in the following cycle.
- i_cpu_cs dropping while in IDLE abandons the request with no RAM access. Dropping in RESP has no effect; ack still pulses.
- Async reset mid-RESP: ack is cleared immediately and FSM returns to IDLE. The RAM op already issued is not retracted.

Optional Feature:
VGA_ARB_PROTOCOL_CHECK_EN
- Defined:
  - Adds output o_proto_err (1 bit, reset 0), sticky until reset.
  - Set when i_vga_cs=1 in a cycle where neither i_vga_access nor i_vga_cs was 1 in the previous cycle (VGA access without notice).
  - Also set when i_vga_cs=1 while a CPU issue occurs. This is unreachable by design and acts as a guard.
- Undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
- CPU write 0x1000<=0x41, then CPU read 0x1000, no VGA activity -> each ack 1 cycle after issue; read o_cpu_dat=0x41 during and after ack.
- VGA access=1 at cycle N, cs at N+1 (addr 0x1000) and N+2 (addr 0x0412), with CPU read pending from N -> CPU issue no earlier than N+3; o_vga_dat=0x41 at N+2; font byte at N+3.
- CPU request while i_vga_access=1 continuously for 10 cycles -> no CPU RAM access, no ack, o_ram_we never 1 from the CPU side.
- CPU read completes between two VGA reads -> o_vga_dat holds the previous VGA byte, unaffected by the CPU data.
- i_reset_n low during RESP -> o_cpu_ack drops asynchronously, FSM IDLE, o_cpu_dat=0.
- With VGA_ARB_PROTOCOL_CHECK_EN: i_vga_cs pulse without preceding i_vga_access -> o_proto_err=1 next cycle and stays 1 until reset.

Source files
------------

// File: rtl/vga_ram_arbiter_if.sv
// Bus bundle between the VGA fetch master, the CPU data bus and the shared RAM.
// VGA_ARB_PROTOCOL_CHECK_EN adds the sticky o_proto_err flag.
interface vga_ram_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    logic                  i_vga_access;
    logic                  i_vga_cs;
    logic [ADDR_WIDTH-1:0] i_vga_addr;
    logic [DATA_WIDTH-1:0] o_vga_dat;

    logic                  i_cpu_cs;
    logic                  i_cpu_we;
    logic [ADDR_WIDTH-1:0] i_cpu_addr;
    logic [DATA_WIDTH-1:0] i_cpu_dat;
    logic [DATA_WIDTH-1:0] o_cpu_dat;
    logic                  o_cpu_ack;

    logic                  o_ram_cs;
    logic                  o_ram_we;
    logic [ADDR_WIDTH-1:0] o_ram_addr;
    logic [DATA_WIDTH-1:0] o_ram_dat;
    logic [DATA_WIDTH-1:0] i_ram_dat;

`ifdef VGA_ARB_PROTOCOL_CHECK_EN
    logic                  o_proto_err;
`endif

    modport slave (
`ifdef VGA_ARB_PROTOCOL_CHECK_EN
        output o_proto_err,
`endif
        input  i_vga_access, i_vga_cs, i_vga_addr,
        output o_vga_dat,
        input  i_cpu_cs, i_cpu_we, i_cpu_addr, i_cpu_dat,
        output o_cpu_dat, o_cpu_ack,
        output o_ram_cs, o_ram_we, o_ram_addr, o_ram_dat,
        input  i_ram_dat
    );

    modport master (
`ifdef VGA_ARB_PROTOCOL_CHECK_EN
        input  o_proto_err,
`endif
        output i_vga_access, i_vga_cs, i_vga_addr,
        input  o_vga_dat,
        output i_cpu_cs, i_cpu_we, i_cpu_addr, i_cpu_dat,
        input  o_cpu_dat, o_cpu_ack,
        input  o_ram_cs, o_ram_we, o_ram_addr, o_ram_dat,
        output i_ram_dat
    );
endinterface

// File: rtl/vga_ram_arbiter.sv
// Single-port RAM sharing: VGA fetches have absolute priority, CPU gets 1-cycle ack.
// Optional VGA_ARB_PROTOCOL_CHECK_EN: sticky o_proto_err on unannounced VGA access.
module vga_ram_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input logic               i_clk,
    input logic               i_reset_n,
    vga_ram_arbiter_if.slave  bus
);
    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  cpu_issue;
    logic                  cpu_rd_q;
    logic                  vga_rd_q;
    logic                  ack;
    logic [DATA_WIDTH-1:0] cpu_dat_q;
    logic [DATA_WIDTH-1:0] vga_hold_q;

    // Blocked in the VGA notice cycle and every VGA cs cycle.
    assign cpu_issue = (state == IDLE) && bus.i_cpu_cs &&
                       !bus.i_vga_access && !bus.i_vga_cs;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (cpu_issue) state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ack = (state == RESP);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cpu_rd_q   <= 1'b0;
            cpu_dat_q  <= '0;
            vga_rd_q   <= 1'b0;
            vga_hold_q <= '0;
        end else begin
            if (cpu_issue) begin
                cpu_rd_q <= !bus.i_cpu_we;
            end
            if (ack && cpu_rd_q) begin
                cpu_dat_q <= bus.i_ram_dat;
            end
            vga_rd_q <= bus.i_vga_cs;
            if (vga_rd_q) begin
                vga_hold_q <= bus.i_ram_dat;
            end
        end
    end

    always_comb begin
        bus.o_ram_cs   = 1'b0;
        bus.o_ram_we   = 1'b0;
        bus.o_ram_addr = {ADDR_WIDTH{1'b0}};
        bus.o_ram_dat  = {DATA_WIDTH{1'b0}};
        if (bus.i_vga_cs) begin
            bus.o_ram_cs   = 1'b1;
            bus.o_ram_addr = bus.i_vga_addr;
        end else if (cpu_issue) begin
            bus.o_ram_cs   = 1'b1;
            bus.o_ram_we   = bus.i_cpu_we;
            bus.o_ram_addr = bus.i_cpu_addr;
            bus.o_ram_dat  = bus.i_cpu_dat;
        end
    end

    // Read data is live during RESP, then held; CPU reads never touch vga_hold_q.
    assign bus.o_cpu_ack = ack;
    assign bus.o_cpu_dat = (ack && cpu_rd_q) ? bus.i_ram_dat : cpu_dat_q;
    assign bus.o_vga_dat = vga_rd_q ? bus.i_ram_dat : vga_hold_q;

`ifdef VGA_ARB_PROTOCOL_CHECK_EN
    logic notice_q;
    logic proto_err_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            notice_q    <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            notice_q <= bus.i_vga_access || bus.i_vga_cs;
            if (bus.i_vga_cs && (!notice_q || cpu_issue)) begin
                proto_err_q <= 1'b1;
            end
        end
    end

    assign bus.o_proto_err = proto_err_q;
`endif
endmodule
